// File: rtl/lcd_st_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_st_pkg
// Purpose  : Constants and per-channel state type shared by the LCD 8<->32
//            bit Avalon-ST packer/unpacker pair.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_st_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int EMPTY_WIDTH    = 2;
    localparam int SYMBOL_WIDTH   = 8;
    localparam int WORD_WIDTH     = BYTES_PER_WORD * SYMBOL_WIDTH;
    localparam int COUNT_WIDTH    = 2;
    localparam int PARTIAL_WIDTH  = (BYTES_PER_WORD - 1) * SYMBOL_WIDTH;

    typedef struct packed {
        logic [COUNT_WIDTH-1:0]   count;
        logic [PARTIAL_WIDTH-1:0] partial;
        logic                     sop_seen;
    } chan_state_t;

    localparam chan_state_t C_CHAN_STATE_IDLE = '0;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } clear_state_t;

    // Places a new symbol into lane (3 - count) on top of the held partial
    // word; lanes below the new symbol stay zero.
    function automatic logic [WORD_WIDTH-1:0] f_merge_byte(
        input logic [PARTIAL_WIDTH-1:0] partial,
        input logic [COUNT_WIDTH-1:0]   count,
        input logic [SYMBOL_WIDTH-1:0]  data
    );
        logic [WORD_WIDTH-1:0] w_word;
        w_word = {partial, {SYMBOL_WIDTH{1'b0}}};
        case (count)
            2'd0:    w_word[31:24] = data;
            2'd1:    w_word[23:16] = data;
            2'd2:    w_word[15:8]  = data;
            default: w_word[7:0]   = data;
        endcase
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_8_to_32_bits_state_regs.sv
`default_nettype none
// ============================================================================
// Module   : lcd_8_to_32_bits_state_regs
// Purpose  : Per-channel packing state register file with asynchronous read,
//            one write port, and a post-reset clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_8_to_32_bits_state_regs
    import lcd_st_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CHANNEL_WIDTH-1:0] i_rd_idx,
    output chan_state_t              o_rd_state,
    input  logic                     i_wr_en,
    input  logic [CHANNEL_WIDTH-1:0] i_wr_idx,
    input  chan_state_t              i_wr_state,
    output logic                     o_clearing
);

    localparam int CHANNELS = 2 ** CHANNEL_WIDTH;

    chan_state_t              r_state [CHANNELS];
    clear_state_t             r_fsm;
    logic [CHANNEL_WIDTH-1:0] r_clear_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm       <= ST_CLEAR;
            r_clear_idx <= CHANNEL_WIDTH'(CHANNELS - 1);
        end else begin
            case (r_fsm)
                ST_CLEAR: begin
                    if (r_clear_idx == '0) begin
                        r_fsm <= ST_RUN;
                    end
                    r_clear_idx <= r_clear_idx - CHANNEL_WIDTH'(1);
                end
                default: begin
                    r_fsm <= ST_RUN;
                end
            endcase
        end
    end

    // Storage has no reset: the clear sequencer zeroes one entry per clock,
    // and writes are impossible while it runs because the sink is held off.
    always_ff @(posedge clk) begin
        if (r_fsm == ST_CLEAR) begin
            r_state[r_clear_idx] <= C_CHAN_STATE_IDLE;
        end else if (i_wr_en) begin
            r_state[i_wr_idx] <= i_wr_state;
        end
    end

    assign o_rd_state = r_state[i_rd_idx];
    assign o_clearing = (r_fsm == ST_CLEAR);

endmodule
`default_nettype wire

// File: rtl/lcd_8_to_32_bits_packer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_8_to_32_bits_packer
// Purpose  : Avalon-ST adapter packing 8-bit symbols into 32-bit words with
//            independent per-channel partial-word state.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_8_to_32_bits_packer
    import lcd_st_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [SYMBOL_WIDTH-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic [CHANNEL_WIDTH-1:0] in_channel,
    output logic [WORD_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [EMPTY_WIDTH-1:0]   out_empty,
    output logic [CHANNEL_WIDTH-1:0] out_channel
);

    chan_state_t            w_rd_state;
    chan_state_t            w_wr_state;
    logic                   w_clearing;
    logic                   w_accept;
    logic                   w_emit;
    logic                   w_sop_flag;
    logic [COUNT_WIDTH-1:0] w_count;
    logic [PARTIAL_WIDTH-1:0] w_partial;
    logic [WORD_WIDTH-1:0]  w_merged;
    logic [EMPTY_WIDTH-1:0] w_empty;

    lcd_8_to_32_bits_state_regs #(
        .CHANNEL_WIDTH (CHANNEL_WIDTH)
    ) u_state_regs (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_rd_idx   (in_channel),
        .o_rd_state (w_rd_state),
        .i_wr_en    (w_accept),
        .i_wr_idx   (in_channel),
        .i_wr_state (w_wr_state),
        .o_clearing (w_clearing)
    );

    // Single output register without skid buffer: a new byte is only taken
    // when the current word is absent or leaving at this edge.
    assign in_ready = !w_clearing && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_count    = in_startofpacket ? '0 : w_rd_state.count;
        w_partial  = in_startofpacket ? '0 : w_rd_state.partial;
        w_sop_flag = in_startofpacket || w_rd_state.sop_seen;
        w_merged   = f_merge_byte(w_partial, w_count, in_data);
        w_emit     = (w_count == COUNT_WIDTH'(BYTES_PER_WORD - 1)) || in_endofpacket;
        w_empty    = in_endofpacket ? (EMPTY_WIDTH'(BYTES_PER_WORD - 1) - w_count) : '0;

        w_wr_state = C_CHAN_STATE_IDLE;
        if (!w_emit) begin
            w_wr_state.count    = w_count + COUNT_WIDTH'(1);
            w_wr_state.partial  = w_merged[WORD_WIDTH-1:SYMBOL_WIDTH];
            w_wr_state.sop_seen = w_sop_flag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_empty         <= '0;
            out_channel       <= '0;
        end else if (w_accept && w_emit) begin
            out_valid         <= 1'b1;
            out_data          <= w_merged;
            out_startofpacket <= w_sop_flag;
            out_endofpacket   <= in_endofpacket;
            out_empty         <= w_empty;
            out_channel       <= in_channel;
        end else if (out_ready) begin
            out_valid         <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_8_to_32_bits_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_8_to_32_bits_packer
// Purpose  : Self-checking bench for the 8-to-32 bit packer with a byte-list
//            reference model and directed plus random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_8_to_32_bits_packer;

    localparam int CW = 1;
    localparam int CH = 2 ** CW;

    logic          clk = 1'b1;
    logic          reset_n = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_startofpacket = 1'b0;
    logic          in_endofpacket = 1'b0;
    logic [CW-1:0] in_channel = '0;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_startofpacket;
    logic          out_endofpacket;
    logic [1:0]    out_empty;
    logic [CW-1:0] out_channel;

    always #5 clk = ~clk;

    lcd_8_to_32_bits_packer #(.CHANNEL_WIDTH(CW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_channel        (in_channel),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .out_channel       (out_channel)
    );

    typedef struct packed {
        logic [31:0]   data;
        logic          sop;
        logic          eop;
        logic [1:0]    empty;
        logic [CW-1:0] ch;
    } word_t;

    word_t      exp_q[$];
    word_t      got_q[$];
    logic [7:0] mbytes [CH][4];
    int         mcnt [CH];
    bit         msop [CH];
    int         compared = 0;
    int         mismatched = 0;
    int         run_edges = 0;
    bit         rnd_bp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Model: a channel is just the list of bytes gathered so far.
    task automatic model_accept(input logic [CW-1:0] ch, input logic [7:0] d, input logic s, input logic e);
        word_t w;
        if (s) begin
            mcnt[ch] = 0;
            msop[ch] = 1'b1;
        end
        mbytes[ch][mcnt[ch]] = d;
        mcnt[ch]++;
        if (mcnt[ch] == 4 || e) begin
            w.data = '0;
            for (int i = 0; i < mcnt[ch]; i++)
                w.data = w.data | (32'(mbytes[ch][i]) << (8 * (3 - i)));
            w.sop   = msop[ch];
            w.eop   = e;
            w.empty = e ? 2'(4 - mcnt[ch]) : 2'd0;
            w.ch    = ch;
            exp_q.push_back(w);
            mcnt[ch] = 0;
            msop[ch] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) run_edges <= 0;
        else          run_edges <= run_edges + 1;
    end

    initial begin : monitor
        logic  exp_rdy;
        word_t g;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_in_ready", in_ready, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_out_sop", out_startofpacket, 0);
                chk("rst_out_eop", out_endofpacket, 0);
                chk("rst_out_empty", out_empty, 0);
                chk("rst_out_channel", out_channel, 0);
                exp_q.delete();
                for (int c = 0; c < CH; c++) begin
                    mcnt[c] = 0;
                    msop[c] = 1'b0;
                end
            end else begin
                exp_rdy = (run_edges >= CH) && (exp_q.size() == 0 || out_ready);
                chk("in_ready", in_ready, exp_rdy);
                chk("out_valid", out_valid, exp_q.size() != 0);
                if (exp_q.size() != 0 && out_valid) begin
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_sop", out_startofpacket, exp_q[0].sop);
                    chk("out_eop", out_endofpacket, exp_q[0].eop);
                    chk("out_empty", out_empty, exp_q[0].empty);
                    chk("out_channel", out_channel, exp_q[0].ch);
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    g.data  = out_data;
                    g.sop   = out_startofpacket;
                    g.eop   = out_endofpacket;
                    g.empty = out_empty;
                    g.ch    = out_channel;
                    got_q.push_back(g);
                    void'(exp_q.pop_front());
                end
                if (in_valid && exp_rdy)
                    model_accept(in_channel, in_data, in_startofpacket, in_endofpacket);
            end
        end
    end

    initial begin : rand_backpressure
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int ch, input logic [7:0] d, input logic s, input logic e);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_channel = ch[CW-1:0];
        in_data = d;
        in_startofpacket = s;
        in_endofpacket = e;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: byte %h not accepted, required accept within 1000 cycles", d);
        end
        in_valid = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic s, input logic e,
                               input logic [1:0] em, input logic [CW-1:0] c);
        word_t w;
        for (int t = 0; t < 50 && got_q.size() == 0; t++) @(posedge clk);
        #1;
        if (got_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_missing: no word delivered, required %h", tag, d);
        end else begin
            w = got_q.pop_front();
            chk({tag, "_data"}, w.data, d);
            chk({tag, "_sop"}, w.sop, s);
            chk({tag, "_eop"}, w.eop, e);
            chk({tag, "_empty"}, w.empty, em);
            chk({tag, "_chan"}, w.ch, c);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset and clear sequence
        #25 reset_n = 1'b1;
        @(posedge clk); #1 chk("clear_edge1_ready", in_ready, 0);
        @(posedge clk); #1 chk("clear_edge2_ready", in_ready, 1);

        // Full word
        send(0, 8'h11, 1, 0); send(0, 8'h22, 0, 0); send(0, 8'h33, 0, 0); send(0, 8'h44, 0, 1);
        expect_word("full", 32'h11223344, 1, 1, 2'd0, 1'b0);

        // Short packets
        send(1, 8'hAA, 1, 0); send(1, 8'hBB, 0, 1);
        expect_word("short2", 32'hAABB0000, 1, 1, 2'd2, 1'b1);
        send(0, 8'h5C, 1, 1);
        expect_word("short1", 32'h5C000000, 1, 1, 2'd3, 1'b0);

        // Interleaved channels
        for (int i = 0; i < 4; i++) begin
            send(0, 8'(8'h01 + i), i == 0, 0);
            send(1, 8'(8'h81 + i), i == 0, 0);
        end
        expect_word("ilv0", 32'h01020304, 1, 0, 2'd0, 1'b0);
        expect_word("ilv1", 32'h81828384, 1, 0, 2'd0, 1'b1);

        // Backpressure holds the word and the sink
        out_ready = 1'b0;
        send(0, 8'hA0, 1, 0); send(0, 8'hA1, 0, 0); send(0, 8'hA2, 0, 0); send(0, 8'hA3, 0, 0);
        in_valid = 1'b1; in_channel = '0; in_data = 8'hB0; in_startofpacket = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 32'hA0A1A2A3);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(0, 8'hB0, 1, 0); send(0, 8'hB1, 0, 0); send(0, 8'hB2, 0, 0); send(0, 8'hB3, 0, 1);
        expect_word("bp_a", 32'hA0A1A2A3, 1, 0, 2'd0, 1'b0);
        expect_word("bp_b", 32'hB0B1B2B3, 1, 1, 2'd0, 1'b0);

        // SOP mid-word discards the held bytes
        send(0, 8'h10, 1, 0); send(0, 8'h20, 0, 0);
        send(0, 8'h30, 1, 0); send(0, 8'h40, 0, 0); send(0, 8'h50, 0, 0); send(0, 8'h60, 0, 1);
        expect_word("drop", 32'h30405060, 1, 1, 2'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1 chk("drop_only_one", got_q.size(), 0);

        // Reset mid-packet with a word pending
        out_ready = 1'b0;
        send(1, 8'h71, 1, 0); send(1, 8'h72, 0, 0);
        send(0, 8'hC0, 1, 0); send(0, 8'hC1, 0, 0); send(0, 8'hC2, 0, 0); send(0, 8'hC3, 0, 0);
        reset_n = 1'b0;
        #1 chk("rst_drops_valid", out_valid, 0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1 chk("reclear_edge1_ready", in_ready, 0);
        @(posedge clk); #1 chk("reclear_edge2_ready", in_ready, 1);
        send(1, 8'h74, 0, 1);
        expect_word("after_rst", 32'h74000000, 0, 1, 2'd3, 1'b1);

        // Random streaming under random backpressure
        got_q.delete();
        rnd_bp = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk);
                #1;
            end
            send($urandom_range(0, CH - 1), 8'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0);
        end
        rnd_bp = 0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("random_drained", exp_q.size(), 0);
        chk("random_words_seen", got_q.size() > 40, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
